// File: rtl/baud_gen_os.sv
// rtl/baud_gen_os.sv - SPART baud generator: oversample tick and bit tick with atomic divisor commit
// Optional fractional divisor enabled by defining BAUD_GEN_FRAC_EN.
module baud_gen_os #(
    parameter int          DIV_W   = 16,
    parameter int          OS      = 16,
    parameter logic [15:0] RST_DIV = 16'd162
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [1:0]       wr_addr,
    input  logic [7:0]       wr_data,
    input  logic             gen_en,
    input  logic             tx_resync,
    output logic             os_tick,
    output logic             bit_tick,
    output logic [DIV_W-1:0] divisor_out
);

    localparam int               OSW         = $clog2(OS);
    localparam logic [DIV_W-1:0] RST_DIV_T   = RST_DIV[DIV_W-1:0];
    localparam logic [OSW-1:0]   OS_LAST     = OSW'(OS - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       stg_q, stg_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [OSW-1:0]   os_cnt_q, os_cnt_d;
    logic             os_tick_q, os_tick_d;
    logic             bit_tick_q, bit_tick_d;

`ifdef BAUD_GEN_FRAC_EN
    logic [3:0]       frac_stg_q, frac_stg_d;
    logic [3:0]       frac_q, frac_d;
    logic [3:0]       acc_q, acc_d;
    // Set when the accumulator carried: the current os period gets one extra clock.
    logic             extra_q, extra_d;
    logic [4:0]       acc_sum;
`endif

    logic             low_wr;
    logic             commit;
    logic [15:0]      new_div_full;
    logic [DIV_W-1:0] new_div;

    assign low_wr       = wr_en && (wr_addr == 2'b10);
    assign commit       = wr_en && (wr_addr == 2'b11);
    assign new_div_full = {wr_data, stg_q};
    assign new_div      = new_div_full[DIV_W-1:0];

`ifdef BAUD_GEN_FRAC_EN
    assign acc_sum = {1'b0, acc_q} + {1'b0, frac_q};
`endif

    // Next-state: commit beats resync beats disable beats normal counting.
    always_comb begin
        div_d      = div_q;
        stg_d      = stg_q;
        cnt_d      = cnt_q;
        os_cnt_d   = os_cnt_q;
        os_tick_d  = 1'b0;
        bit_tick_d = 1'b0;
`ifdef BAUD_GEN_FRAC_EN
        frac_stg_d = frac_stg_q;
        frac_d     = frac_q;
        acc_d      = acc_q;
        extra_d    = extra_q;
        if (wr_en && (wr_addr == 2'b01)) begin
            frac_stg_d = wr_data[3:0];
        end
`endif
        if (low_wr) begin
            stg_d = wr_data;
        end

        if (commit) begin
            div_d    = new_div;
            cnt_d    = new_div;
            os_cnt_d = '0;
`ifdef BAUD_GEN_FRAC_EN
            frac_d   = frac_stg_q;
            acc_d    = 4'd0;
            extra_d  = 1'b0;
`endif
        end else if (tx_resync || !gen_en) begin
            cnt_d    = div_q;
            os_cnt_d = '0;
`ifdef BAUD_GEN_FRAC_EN
            acc_d    = 4'd0;
            extra_d  = 1'b0;
`endif
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - DIV_W'(1);
`ifdef BAUD_GEN_FRAC_EN
        end else if (extra_q) begin
            extra_d = 1'b0;
`endif
        end else begin
            cnt_d     = div_q;
            os_tick_d = 1'b1;
            if (os_cnt_q == OS_LAST) begin
                os_cnt_d   = '0;
                bit_tick_d = 1'b1;
            end else begin
                os_cnt_d = os_cnt_q + OSW'(1);
            end
`ifdef BAUD_GEN_FRAC_EN
            acc_d   = acc_sum[3:0];
            extra_d = acc_sum[4];
`endif
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q      <= RST_DIV_T;
            stg_q      <= 8'd0;
            cnt_q      <= RST_DIV_T;
            os_cnt_q   <= '0;
            os_tick_q  <= 1'b0;
            bit_tick_q <= 1'b0;
`ifdef BAUD_GEN_FRAC_EN
            frac_stg_q <= 4'd0;
            frac_q     <= 4'd0;
            acc_q      <= 4'd0;
            extra_q    <= 1'b0;
`endif
        end else begin
            div_q      <= div_d;
            stg_q      <= stg_d;
            cnt_q      <= cnt_d;
            os_cnt_q   <= os_cnt_d;
            os_tick_q  <= os_tick_d;
            bit_tick_q <= bit_tick_d;
`ifdef BAUD_GEN_FRAC_EN
            frac_stg_q <= frac_stg_d;
            frac_q     <= frac_d;
            acc_q      <= acc_d;
            extra_q    <= extra_d;
`endif
        end
    end

    assign os_tick     = os_tick_q;
    assign bit_tick    = bit_tick_q;
    assign divisor_out = div_q;

endmodule
